// File: rtl/perceptron_pkg.sv
// perceptron_pkg
//  Shared types and helpers for the perceptron trainer and the inference neuron.
//  - state_t    : trainer FSM states
//  - DEF_*      : default input count and weight width
//  - SUM_WIDTH  : width of the weighted sum for the default sizes
//  - sat_add    : signed add clamped to a two's complement range of a given width
package perceptron_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EVAL   = 2'd1,
        S_UPDATE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int DEF_N_IN    = 2;
    localparam int DEF_W_WIDTH = 4;
    localparam int SUM_WIDTH   = DEF_W_WIDTH + $clog2(DEF_N_IN + 1);

    function automatic int sat_add(input int a, input int e, input int width);
        int s;
        int hi;
        int lo;
        s  = a + e;
        hi = (1 << (width - 1)) - 1;
        lo = -(1 << (width - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/perceptron_dot.sv
// perceptron_dot
//  Combinational weighted sum and threshold of a single neuron.
//  Ports:
//   weights  in   N_IN*W_WIDTH  signed weights, w_i at [i*W_WIDTH +: W_WIDTH]
//   bias     in   W_WIDTH       signed bias
//   x        in   N_IN          binary input vector
//   sum      out  SUM_W         bias + sum of weights whose input bit is set
//   y        out  1             sum >= 1
module perceptron_dot
    import perceptron_pkg::*;
#(
    parameter int N_IN    = DEF_N_IN,
    parameter int W_WIDTH = DEF_W_WIDTH,
    parameter int SUM_W   = W_WIDTH + $clog2(N_IN + 1)
) (
    input  logic [N_IN*W_WIDTH-1:0] weights,
    input  logic [W_WIDTH-1:0]      bias,
    input  logic [N_IN-1:0]         x,
    output logic [SUM_W-1:0]        sum,
    output logic                    y
);

    logic [SUM_W-1:0] acc;

    // Operands are sign-extended by hand; SUM_W is wide enough that no overflow occurs.
    always_comb begin
        acc = {{(SUM_W-W_WIDTH){bias[W_WIDTH-1]}}, bias};
        for (int i = 0; i < N_IN; i++) begin
            if (x[i]) begin
                acc = acc + {{(SUM_W-W_WIDTH){weights[i*W_WIDTH+W_WIDTH-1]}},
                             weights[i*W_WIDTH +: W_WIDTH]};
            end
        end
    end

    assign sum = acc;
    assign y   = !acc[SUM_W-1] && (acc != '0);

endmodule

// File: rtl/perceptron_trainer.sv
// perceptron_trainer
//  Perceptron-rule trainer (lr = 1) for a single binary neuron; exports weights/bias.
//  state    | meaning
//  S_IDLE   | waiting for a sample, load or restart
//  S_EVAL   | evaluate latched sample, record prediction and error
//  S_UPDATE | apply saturating weight/bias update, close epoch on last sample
//  S_DONE   | converged or epoch limit reached; weights frozen
//  Ports:
//   clk, rst                          clock, synchronous active-high reset
//   sample_valid/ready/x/label/last   sample handshake
//   load_en, load_w, load_b           preset weights/bias in IDLE or DONE
//   restart                           clear counters, keep weights
//   weights, bias, y_pred             trained state and last prediction
//   busy, done, converged, epoch_count status
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int N_IN       = DEF_N_IN,
    parameter int W_WIDTH    = DEF_W_WIDTH,
    parameter int MAX_EPOCHS = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic [N_IN-1:0]         sample_x,
    input  logic                    sample_label,
    input  logic                    sample_last,
    input  logic                    load_en,
    input  logic [N_IN*W_WIDTH-1:0] load_w,
    input  logic [W_WIDTH-1:0]      load_b,
    input  logic                    restart,
    output logic [N_IN*W_WIDTH-1:0] weights,
    output logic [W_WIDTH-1:0]      bias,
    output logic                    y_pred,
    output logic                    busy,
    output logic                    done,
    output logic                    converged,
    output logic [7:0]              epoch_count
);

    localparam int SUM_W = W_WIDTH + $clog2(N_IN + 1);

    state_t                  state_q, state_d;
    logic [N_IN*W_WIDTH-1:0] w_q;
    logic [W_WIDTH-1:0]      b_q;
    logic [N_IN-1:0]         x_q;
    logic                    label_q, last_q;
    logic                    err_q, err_pos_q, err_any_q;
    logic                    y_q, conv_q;
    logic [7:0]              epoch_q;
    logic [SUM_W-1:0]        eval_sum;
    logic                    eval_y;
    logic                    unused_sum_parity;
    logic                    at_limit;
    int                      e_val;

    perceptron_dot #(.N_IN(N_IN), .W_WIDTH(W_WIDTH), .SUM_W(SUM_W)) u_dot (
        .weights (w_q),
        .bias    (b_q),
        .x       (x_q),
        .sum     (eval_sum),
        .y       (eval_y)
    );

    // The raw sum is only needed by the inference side.
    assign unused_sum_parity = ^eval_sum;
    assign at_limit          = (epoch_q == 8'(MAX_EPOCHS - 1));
    assign e_val             = err_pos_q ? 1 : -1;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        sample_ready = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_q)
            S_IDLE: begin
                sample_ready = ~load_en;
                if (sample_valid && !load_en) state_d = S_EVAL;
            end
            S_EVAL: begin
                busy    = 1'b1;
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                busy = 1'b1;
                if (!last_q)        state_d = S_IDLE;
                else if (!err_any_q) state_d = S_DONE;
                else if (at_limit)  state_d = S_DONE;
                else                state_d = S_IDLE;
            end
            S_DONE: begin
                done = 1'b1;
                if (load_en || restart) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q       <= '0;
            b_q       <= '0;
            x_q       <= '0;
            label_q   <= 1'b0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
            err_pos_q <= 1'b0;
            err_any_q <= 1'b0;
            y_q       <= 1'b0;
            conv_q    <= 1'b0;
            epoch_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (load_en) begin
                        w_q       <= load_w;
                        b_q       <= load_b;
                        epoch_q   <= '0;
                        err_any_q <= 1'b0;
                        conv_q    <= 1'b0;
                    end else if (restart) begin
                        epoch_q   <= '0;
                        err_any_q <= 1'b0;
                        conv_q    <= 1'b0;
                    end
                    if (state_q == S_IDLE && sample_valid && !load_en) begin
                        x_q     <= sample_x;
                        label_q <= sample_label;
                        last_q  <= sample_last;
                    end
                end
                S_EVAL: begin
                    y_q       <= eval_y;
                    err_q     <= (label_q != eval_y);
                    err_pos_q <= label_q;
                    err_any_q <= err_any_q | (label_q != eval_y);
                end
                S_UPDATE: begin
                    if (err_q) begin
                        for (int i = 0; i < N_IN; i++) begin
                            if (x_q[i]) begin
                                w_q[i*W_WIDTH +: W_WIDTH] <= W_WIDTH'(sat_add(
                                    int'($signed(w_q[i*W_WIDTH +: W_WIDTH])), e_val, W_WIDTH));
                            end
                        end
                        b_q <= W_WIDTH'(sat_add(int'($signed(b_q)), e_val, W_WIDTH));
                    end
                    if (last_q) begin
                        epoch_q <= epoch_q + 8'd1;
                        if (!err_any_q)    conv_q    <= 1'b1;
                        else if (at_limit) conv_q    <= 1'b0;
                        else               err_any_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign weights     = w_q;
    assign bias        = b_q;
    assign y_pred      = y_q;
    assign converged   = conv_q;
    assign epoch_count = epoch_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
module tb_perceptron_trainer;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_valid;
    logic       sample_ready;
    logic [1:0] sample_x;
    logic       sample_label;
    logic       sample_last;
    logic       load_en;
    logic [7:0] load_w;
    logic [3:0] load_b;
    logic       restart;
    logic [7:0] weights;
    logic [3:0] bias;
    logic       y_pred;
    logic       busy;
    logic       done;
    logic       converged;
    logic [7:0] epoch_count;

    always #5 clk = ~clk;

    perceptron_trainer dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_x     (sample_x),
        .sample_label (sample_label),
        .sample_last  (sample_last),
        .load_en      (load_en),
        .load_w       (load_w),
        .load_b       (load_b),
        .restart      (restart),
        .weights      (weights),
        .bias         (bias),
        .y_pred       (y_pred),
        .busy         (busy),
        .done         (done),
        .converged    (converged),
        .epoch_count  (epoch_count)
    );

    typedef struct {
        logic       y;
        logic [7:0] w;
        logic [3:0] b;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model: m_w[0] pairs with sample_x[0]
    int m_w[2];
    int m_b;
    int m_epoch;
    bit m_err, m_done, m_conv;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int clamp4(input int v);
        if (v > 7)  return 7;
        if (v < -8) return -8;
        return v;
    endfunction

    function automatic logic [7:0] model_w();
        logic [7:0] r;
        r[7:4] = 4'(m_w[1]);
        r[3:0] = 4'(m_w[0]);
        return r;
    endfunction

    task automatic model_clear();
        m_w[0] = 0; m_w[1] = 0; m_b = 0;
        m_epoch = 0; m_err = 0; m_done = 0; m_conv = 0;
    endtask

    task automatic model_step(input logic [1:0] x, input logic label, input logic last);
        int   sum;
        int   e;
        logic y;
        exp_t ex;
        sum = m_b + (x[0] ? m_w[0] : 0) + (x[1] ? m_w[1] : 0);
        y   = (sum >= 1);
        e   = int'(label) - int'(y);
        if (e != 0) begin
            m_err = 1;
            for (int i = 0; i < 2; i++) if (x[i]) m_w[i] = clamp4(m_w[i] + e);
            m_b = clamp4(m_b + e);
        end
        if (last) begin
            m_epoch++;
            if (!m_err) begin
                m_conv = 1; m_done = 1;
            end else if (m_epoch == 15) begin
                m_conv = 0; m_done = 1;
            end else begin
                m_err = 0;
            end
        end
        ex.y = y; ex.w = model_w(); ex.b = 4'(m_b);
        sb_q.push_back(ex);
    endtask

    // called at a negedge; bounded wait for sample_ready
    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (sample_ready) begin
                ok = 1;
                return;
            end
            @(negedge clk);
        end
        check_eq("ready_timeout", 32'(sample_ready), 32'd1);
    endtask

    task automatic send_sample(input logic [1:0] x, input logic label, input logic last);
        bit   ok;
        exp_t ex;
        wait_ready(ok);
        if (!ok) return;
        model_step(x, label, last);
        sample_x = x; sample_label = label; sample_last = last; sample_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
            return;
        end
        ex = sb_q.pop_front();
        check_eq("y_pred",  32'(y_pred),  32'(ex.y));
        check_eq("weights", 32'(weights), 32'(ex.w));
        check_eq("bias",    32'(bias),    32'(ex.b));
    endtask

    task automatic run_epoch(input logic [3:0] lbl);
        for (int i = 0; i < 4; i++) send_sample(2'(i), lbl[i], i == 3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic do_load(input logic [7:0] w, input logic [3:0] b);
        @(negedge clk);
        load_en = 1'b1; load_w = w; load_b = b;
        @(posedge clk);
        @(negedge clk);
        load_en = 1'b0;
        m_w[1] = int'($signed(w[7:4]));
        m_w[0] = int'($signed(w[3:0]));
        m_b    = int'($signed(b));
        m_epoch = 0; m_err = 0; m_done = 0; m_conv = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sample_valid = 1'b0; sample_x = '0; sample_label = 1'b0; sample_last = 1'b0;
        load_en = 1'b0; load_w = '0; load_b = '0; restart = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // reset state
        check_eq("rst_ready",  32'(sample_ready), 32'd1);
        check_eq("rst_busy",   32'(busy),         32'd0);
        check_eq("rst_done",   32'(done),         32'd0);
        check_eq("rst_w",      32'(weights),      32'd0);
        check_eq("rst_b",      32'(bias),         32'd0);
        check_eq("rst_epoch",  32'(epoch_count),  32'd0);
        check_eq("rst_conv",   32'(converged),    32'd0);
        check_eq("rst_y",      32'(y_pred),       32'd0);

        // AND training from reset
        for (int ep = 0; ep < 20 && !m_done; ep++) run_epoch(4'b1000);
        check_eq("and_done",     32'(done),        32'(m_done));
        check_eq("and_conv",     32'(converged),   32'd1);
        check_eq("and_epoch",    32'(epoch_count), 32'd6);
        check_eq("and_w",        32'(weights),     32'h21);
        check_eq("and_b",        32'(bias),        32'hE);
        check_eq("and_ready",    32'(sample_ready), 32'd0);

        // restart from DONE keeps weights
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        @(negedge clk);
        restart = 1'b0;
        m_epoch = 0; m_err = 0; m_done = 0; m_conv = 0;
        check_eq("rs_done",  32'(done),         32'd0);
        check_eq("rs_ready", 32'(sample_ready), 32'd1);
        check_eq("rs_epoch", 32'(epoch_count),  32'd0);
        check_eq("rs_conv",  32'(converged),    32'd0);
        check_eq("rs_w",     32'(weights),      32'h21);
        check_eq("rs_b",     32'(bias),         32'hE);

        // one erroneous single-sample epoch so the epoch counter is non-zero
        send_sample(2'b11, 1'b0, 1'b1);
        check_eq("ep1_epoch", 32'(epoch_count), 32'(m_epoch));
        check_eq("ep1_done",  32'(done),        32'd0);

        // reset while in UPDATE
        begin
            bit ok;
            wait_ready(ok);
            sample_x = 2'b11; sample_label = 1'b1; sample_last = 1'b1; sample_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            sample_valid = 1'b0;
            check_eq("mid_eval_busy", 32'(busy), 32'd1);
            @(posedge clk);
            @(negedge clk);
            check_eq("mid_upd_busy", 32'(busy), 32'd1);
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            model_clear();
            check_eq("mid_ready", 32'(sample_ready), 32'd1);
            check_eq("mid_busy",  32'(busy),         32'd0);
            check_eq("mid_w",     32'(weights),      32'd0);
            check_eq("mid_b",     32'(bias),         32'd0);
            check_eq("mid_epoch", 32'(epoch_count),  32'd0);
        end

        // load_en and sample_valid in the same IDLE cycle: load wins, no handshake
        @(negedge clk);
        load_en = 1'b1; load_w = 8'h35; load_b = 4'h1;
        sample_valid = 1'b1; sample_x = 2'b11; sample_label = 1'b1; sample_last = 1'b1;
        #1;
        check_eq("lvs_ready", 32'(sample_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        load_en = 1'b0; sample_valid = 1'b0;
        m_w[1] = 3; m_w[0] = 5; m_b = 1;
        check_eq("lvs_busy",  32'(busy),    32'd0);
        check_eq("lvs_w",     32'(weights), 32'h35);
        check_eq("lvs_b",     32'(bias),    32'h1);
        @(posedge clk);
        @(negedge clk);
        check_eq("lvs_noeval", 32'(busy), 32'd0);

        // saturation: bias held at +7
        do_load(8'h80, 4'h7);
        send_sample(2'b10, 1'b1, 1'b0);
        check_eq("sat_w", 32'(weights), 32'h90);
        check_eq("sat_b", 32'(bias),    32'h7);

        // XOR never converges: epoch limit
        do_reset();
        for (int ep = 0; ep < 20 && !m_done; ep++) run_epoch(4'b0110);
        check_eq("xor_done",  32'(done),         32'd1);
        check_eq("xor_conv",  32'(converged),    32'd0);
        check_eq("xor_epoch", 32'(epoch_count),  32'd15);
        check_eq("xor_ready", 32'(sample_ready), 32'd0);
        @(negedge clk);
        sample_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sample_valid = 1'b0;
        check_eq("xor_hold_busy",  32'(busy),         32'd0);
        check_eq("xor_hold_ready", 32'(sample_ready), 32'd0);
        check_eq("xor_hold_w",     32'(weights),      32'(model_w()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
